// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the eight-way round-robin arbiter.
package rr_arb_pkg;
    localparam int ARB_N = 8;
    localparam int ARB_W = 3;

    typedef logic [ARB_W-1:0] arb_idx_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;
endpackage

// File: rtl/rr_pick8.sv
// Circular find-first-set: rotate requests down by the pointer, take the lowest
// set bit, then add the pointer back to recover the absolute winner index.
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [ARB_N-1:0] i_req,
    input  arb_idx_t         i_ptr,
    input  logic [ARB_N-1:0] i_mask,
    output logic [ARB_N-1:0] o_onehot,
    output arb_idx_t         o_idx,
    output logic             o_any
);
    logic [ARB_N-1:0]   w_req;
    logic [2*ARB_N-1:0] w_dbl;
    logic [ARB_N-1:0]   w_rot;
    arb_idx_t           w_off;

    always_comb begin
        w_req = i_req & ~i_mask;
        w_dbl = {w_req, w_req} >> i_ptr;
        w_rot = w_dbl[ARB_N-1:0];
        w_off = '0;
        // Scan high-to-low so the lowest set bit is the last one written.
        for (int k = ARB_N - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = arb_idx_t'(k);
        end
        o_any    = |w_rot;
        o_idx    = i_ptr + w_off;
        o_onehot = o_any ? (ARB_N'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot grant and valid/ready.
// Define RR_ARBITER8_LOCK_EN to add i_lock (hold pointer and re-grant for bursts).
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int unsigned RESET_PTR = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [ARB_N-1:0] i_req,
    input  logic             i_ready,
`ifdef RR_ARBITER8_LOCK_EN
    input  logic             i_lock,
`endif
    output logic             o_valid,
    output logic [ARB_N-1:0] o_grant,
    output arb_idx_t         o_ptr
);
    localparam arb_idx_t PTR_RST = arb_idx_t'(RESET_PTR);

    arb_state_e       r_state, w_state_nxt;
    logic [ARB_N-1:0] r_grant, w_grant_nxt;
    arb_idx_t         r_ptr, w_ptr_nxt;
    arb_idx_t         r_idx, w_idx_nxt;

    logic             w_hs, w_adv;
    arb_idx_t         w_pick_ptr;
    logic [ARB_N-1:0] w_pick_mask;
    logic [ARB_N-1:0] w_pick;
    arb_idx_t         w_pick_idx;
    logic             w_pick_any;

    assign w_hs = (r_state == ARB_GRANT) && i_ready;
`ifdef RR_ARBITER8_LOCK_EN
    assign w_adv = w_hs && !i_lock;
`else
    assign w_adv = w_hs;
`endif

    // Advancing handshake picks from past the winner with the winner masked off.
    assign w_pick_ptr  = w_adv ? r_idx + arb_idx_t'(1) : r_ptr;
    assign w_pick_mask = w_adv ? r_grant : '0;

    rr_pick8 u_pick (
        .i_req    (i_req),
        .i_ptr    (w_pick_ptr),
        .i_mask   (w_pick_mask),
        .o_onehot (w_pick),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_idx;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ARB_GRANT;
                    w_grant_nxt = w_pick;
                    w_idx_nxt   = w_pick_idx;
                end
            end
            ARB_GRANT: begin
                if (w_hs) begin
                    w_ptr_nxt = w_pick_ptr;
                    if (w_pick_any) begin
                        w_grant_nxt = w_pick;
                        w_idx_nxt   = w_pick_idx;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                        w_grant_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_ptr   <= PTR_RST;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    assign o_valid = (r_state == ARB_GRANT);
    assign o_grant = r_grant;
    assign o_ptr   = r_ptr;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed-vector bench for rr_arbiter8 (RESET_PTR = 0); lock burst case runs
// only when RR_ARBITER8_LOCK_EN is defined.
module tb_rr_arbiter8;
    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ready;
`ifdef RR_ARBITER8_LOCK_EN
    logic       lock;
`endif
    logic       valid;
    logic [7:0] grant;
    logic [2:0] ptr;

    int n_chk  = 0;
    int n_fail = 0;

    rr_arbiter8 #(.RESET_PTR(0)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_ready (ready),
`ifdef RR_ARBITER8_LOCK_EN
        .i_lock  (lock),
`endif
        .o_valid (valid),
        .o_grant (grant),
        .o_ptr   (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] g, input logic [2:0] p);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
        chk({tag, ".grant"}, {24'd0, grant}, {24'd0, g});
        chk({tag, ".ptr"},   {29'd0, ptr},   {29'd0, p});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_g;
        rst = 1'b1;
        req = 8'h00;
        ready = 1'b0;
`ifdef RR_ARBITER8_LOCK_EN
        lock = 1'b0;
`endif
        do_reset();
        chk_out("reset", 1'b0, 8'h00, 3'd0);

        // Two-way contention between the ends of the vector.
        req = 8'h81; ready = 1'b1;
        step(); chk_out("t81.0", 1'b1, 8'h01, 3'd0);
        step(); chk_out("t81.1", 1'b1, 8'h80, 3'd1);
        step(); chk_out("t81.2", 1'b1, 8'h01, 3'd0);
        step(); chk_out("t81.3", 1'b1, 8'h80, 3'd1);

        // Full contention rotates strictly, one grant per cycle.
        do_reset();
        req = 8'hFF; ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_g = 8'h01 << (i % 8);
            chk_out($sformatf("tff.%0d", i), 1'b1, exp_g, 3'(i % 8));
            chk($sformatf("tff.onehot%0d", i), $countones(grant), 32'd1);
        end

        // Stall: hold 04 while requests change (winner even drops its request).
        req = 8'h04;
        step(); chk_out("stall.load", 1'b1, 8'h04, 3'd2);
        ready = 1'b0; req = 8'h02;
        for (int i = 0; i < 3; i++) begin
            step(); chk_out($sformatf("stall.%0d", i), 1'b1, 8'h04, 3'd2);
        end
        ready = 1'b1;
        step(); chk_out("stall.rel", 1'b1, 8'h02, 3'd3);

        // Single one-cycle request then idle; ready in idle is ignored.
        req = 8'h10;
        step(); chk_out("single.g", 1'b1, 8'h10, 3'd2);
        req = 8'h00;
        step(); chk_out("single.idle", 1'b0, 8'h00, 3'd5);
        step(); chk_out("single.idle2", 1'b0, 8'h00, 3'd5);

        // Latency from idle, then reset mid-grant.
        ready = 1'b0; req = 8'h08;
        step(); chk_out("lat.08", 1'b1, 8'h08, 3'd5);
        rst = 1'b1;
        step(); chk_out("rst.mid", 1'b0, 8'h00, 3'd0);
        rst = 1'b0; req = 8'h00;
        step(); chk_out("rst.after", 1'b0, 8'h00, 3'd0);

`ifdef RR_ARBITER8_LOCK_EN
        // Locked handshakes re-grant the same winner without moving the pointer.
        do_reset();
        req = 8'h06; ready = 1'b1; lock = 1'b1;
        step(); chk_out("lock.0", 1'b1, 8'h02, 3'd0);
        step(); chk_out("lock.1", 1'b1, 8'h02, 3'd0);
        step(); chk_out("lock.2", 1'b1, 8'h02, 3'd0);
        step(); chk_out("lock.3", 1'b1, 8'h02, 3'd0);
        lock = 1'b0;
        step(); chk_out("lock.rel", 1'b1, 8'h04, 3'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
